// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three-master Wishbone arbiter in front of the SDRAM controller (m0 > m1 > m2).
// Define SDRAM_ARB_STARVE_EN to let a starved m1/m2 request pre-empt fixed priority.
module sdram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,

    input  logic [23:0] m0_adr,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel,
    input  logic [2:0]  m0_cti,
    input  logic        m0_stb,
    input  logic        m0_cyc,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_dat_o,

    input  logic [23:0] m1_adr,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel,
    input  logic [2:0]  m1_cti,
    input  logic        m1_stb,
    input  logic        m1_cyc,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_dat_o,

    input  logic [23:0] m2_adr,
    input  logic [31:0] m2_dat_i,
    input  logic [3:0]  m2_sel,
    input  logic [2:0]  m2_cti,
    input  logic        m2_stb,
    input  logic        m2_cyc,
    input  logic        m2_we,
    output logic        m2_ack,
    output logic [31:0] m2_dat_o,

    output logic [23:0] s_adr,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel,
    output logic [2:0]  s_cti,
    output logic        s_stb,
    output logic        s_cyc,
    output logic        s_we,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack,

    output logic [1:0]  grant
);

    localparam int unsigned CNTW       = 8;
    localparam logic [1:0]  GRANT_NONE = 2'd3;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("sdram_arbiter: STARVE_LIMIT must be 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_RELEASE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  grant_d;
    logic [2:0]  req;
    logic [1:0]  winner;
    logic        win_valid;
    logic        own_cyc;
    logic        starve1;
    logic        starve2;

    assign req = {m2_cyc & m2_stb, m1_cyc & m1_stb, m0_cyc & m0_stb};

`ifdef SDRAM_ARB_STARVE_EN
    localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

    logic [CNTW-1:0] wait1_q;
    logic [CNTW-1:0] wait2_q;

    function automatic logic [CNTW-1:0] wait_next(input logic [CNTW-1:0] cur,
                                                  input logic            r,
                                                  input logic            owned);
        if (!r || owned)
            return '0;
        else if (cur >= LIMIT)
            return LIMIT;
        else
            return cur + CNTW'(1);
    endfunction

    assign starve1 = req[1] && (wait1_q == LIMIT);
    assign starve2 = req[2] && (wait2_q == LIMIT);

    // Wait counters clear when the master owns the port or is picked this cycle.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wait1_q <= '0;
            wait2_q <= '0;
        end else begin
            wait1_q <= wait_next(wait1_q, req[1],
                                 (grant == 2'd1) || (state_q == ST_IDLE && winner == 2'd1));
            wait2_q <= wait_next(wait2_q, req[2],
                                 (grant == 2'd2) || (state_q == ST_IDLE && winner == 2'd2));
        end
    end
`else
    assign starve1 = 1'b0;
    assign starve2 = 1'b0;
`endif

    // Winner selection: promoted waiters first, then fixed priority.
    always_comb begin
        win_valid = |req;
        winner    = GRANT_NONE;
        if (starve1)
            winner = 2'd1;
        else if (starve2)
            winner = 2'd2;
        else if (req[0])
            winner = 2'd0;
        else if (req[1])
            winner = 2'd1;
        else if (req[2])
            winner = 2'd2;
    end

    always_comb begin
        own_cyc = 1'b0;
        case (grant)
            2'd0:    own_cyc = m0_cyc;
            2'd1:    own_cyc = m1_cyc;
            2'd2:    own_cyc = m2_cyc;
            default: own_cyc = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            grant   <= GRANT_NONE;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        case (state_q)
            ST_IDLE: begin
                grant_d = GRANT_NONE;
                if (win_valid) begin
                    state_d = ST_OWN;
                    grant_d = winner;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_d = ST_RELEASE;
                    grant_d = GRANT_NONE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    // Slave-side mux: owner's signals pass straight through, otherwise all zero.
    always_comb begin
        s_adr   = '0;
        s_dat_o = '0;
        s_sel   = '0;
        s_cti   = '0;
        s_stb   = 1'b0;
        s_cyc   = 1'b0;
        s_we    = 1'b0;
        if (state_q == ST_OWN) begin
            case (grant)
                2'd0: begin
                    s_adr = m0_adr; s_dat_o = m0_dat_i; s_sel = m0_sel; s_cti = m0_cti;
                    s_stb = m0_stb; s_cyc = m0_cyc;     s_we  = m0_we;
                end
                2'd1: begin
                    s_adr = m1_adr; s_dat_o = m1_dat_i; s_sel = m1_sel; s_cti = m1_cti;
                    s_stb = m1_stb; s_cyc = m1_cyc;     s_we  = m1_we;
                end
                2'd2: begin
                    s_adr = m2_adr; s_dat_o = m2_dat_i; s_sel = m2_sel; s_cti = m2_cti;
                    s_stb = m2_stb; s_cyc = m2_cyc;     s_we  = m2_we;
                end
                default: ;
            endcase
        end
    end

    // Late acks after release land on grant==3 and reach nobody.
    assign m0_ack   = s_ack & (grant == 2'd0);
    assign m1_ack   = s_ack & (grant == 2'd1);
    assign m2_ack   = s_ack & (grant == 2'd2);
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m2_dat_o = s_dat_i;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios plus random traffic against a transaction-level
// ownership model (owner / dead-gap / wait counts). Honors SDRAM_ARB_STARVE_EN.
module tb_sdram_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [23:0] adr  [3];
    logic [31:0] dat  [3];
    logic [3:0]  sel  [3];
    logic [2:0]  cti  [3];
    logic        stb  [3];
    logic        cyc  [3];
    logic        we   [3];
    logic [31:0] s_dat_i;
    logic        s_ack;

    logic        m0_ack, m1_ack, m2_ack;
    logic [31:0] m0_dat_o, m1_dat_o, m2_dat_o;
    logic [23:0] s_adr;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic        s_stb, s_cyc, s_we;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the port, whether a dead RELEASE cycle is pending, waits.
    int m_owner = 3;
    bit m_gap   = 1'b0;
    int m_wait [3];

    always #5 wb_clk = ~wb_clk;

    sdram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .m0_adr(adr[0]), .m0_dat_i(dat[0]), .m0_sel(sel[0]), .m0_cti(cti[0]),
        .m0_stb(stb[0]), .m0_cyc(cyc[0]), .m0_we(we[0]), .m0_ack(m0_ack), .m0_dat_o(m0_dat_o),
        .m1_adr(adr[1]), .m1_dat_i(dat[1]), .m1_sel(sel[1]), .m1_cti(cti[1]),
        .m1_stb(stb[1]), .m1_cyc(cyc[1]), .m1_we(we[1]), .m1_ack(m1_ack), .m1_dat_o(m1_dat_o),
        .m2_adr(adr[2]), .m2_dat_i(dat[2]), .m2_sel(sel[2]), .m2_cti(cti[2]),
        .m2_stb(stb[2]), .m2_cyc(cyc[2]), .m2_we(we[2]), .m2_ack(m2_ack), .m2_dat_o(m2_dat_o),
        .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel), .s_cti(s_cti),
        .s_stb(s_stb), .s_cyc(s_cyc), .s_we(s_we), .s_dat_i(s_dat_i), .s_ack(s_ack),
        .grant(grant)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1, input bit r2);
`ifdef SDRAM_ARB_STARVE_EN
        if (r1 && m_wait[1] == int'(LIMIT)) return 1;
        if (r2 && m_wait[2] == int'(LIMIT)) return 2;
`endif
        if (r0) return 0;
        if (r1) return 1;
        if (r2) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_owner = 3;
        m_gap   = 1'b0;
        for (int n = 0; n < 3; n++) m_wait[n] = 0;
    endtask

    task automatic model_step();
        bit r [3];
        int win;
        if (!wb_rst_n) begin
            model_reset();
            return;
        end
        for (int n = 0; n < 3; n++) r[n] = cyc[n] && stb[n];
        win = (m_owner == 3 && !m_gap) ? pick(r[0], r[1], r[2]) : 3;
        for (int n = 1; n < 3; n++) begin
            if (!r[n] || m_owner == n || win == n) m_wait[n] = 0;
            else if (m_wait[n] < int'(LIMIT))      m_wait[n]++;
        end
        if (m_owner != 3) begin
            if (!cyc[m_owner]) begin
                m_owner = 3;
                m_gap   = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            m_owner = win;
        end
    endtask

    task automatic compare_all();
        logic [33:0] exp_bus;
        logic [31:0] exp_dat;
        logic [2:0]  exp_ack;
        exp_bus = '0;
        exp_dat = '0;
        exp_ack = '0;
        if (m_owner != 3) begin
            exp_bus = {cyc[m_owner], stb[m_owner], we[m_owner], cti[m_owner],
                       sel[m_owner], adr[m_owner]};
            exp_dat = dat[m_owner];
            exp_ack[m_owner] = s_ack;
        end
        check("grant",   128'(grant), 128'(m_owner));
        check("s_bus",   128'({s_cyc, s_stb, s_we, s_cti, s_sel, s_adr}), 128'(exp_bus));
        check("s_dat_o", 128'(s_dat_o), 128'(exp_dat));
        check("acks",    128'({m2_ack, m1_ack, m0_ack}), 128'(exp_ack));
        check("dat_o",   128'({m2_dat_o, m1_dat_o, m0_dat_o}), 128'({3{s_dat_i}}));
    endtask

    // Inputs are set at the falling edge; step compares, then clocks the model once.
    task automatic step();
        #1 compare_all();
        @(posedge wb_clk);
        model_step();
        @(negedge wb_clk);
    endtask

    task automatic req(input int n, input logic [23:0] a, input logic w, input logic [2:0] ct);
        cyc[n] = 1'b1; stb[n] = 1'b1; adr[n] = a; we[n] = w; cti[n] = ct;
        dat[n] = $urandom; sel[n] = 4'hf;
    endtask

    task automatic idle_all();
        for (int n = 0; n < 3; n++) begin
            cyc[n] = 1'b0; stb[n] = 1'b0;
        end
        s_ack = 1'b0;
        repeat (3) step();
    endtask

    bit saw_m2;

    initial begin
        wb_rst_n = 1'b0;
        s_ack    = 1'b0;
        s_dat_i  = '0;
        for (int n = 0; n < 3; n++) begin
            adr[n] = '0; dat[n] = '0; sel[n] = '0; cti[n] = '0;
            stb[n] = 1'b0; cyc[n] = 1'b0; we[n] = 1'b0;
        end
        model_reset();
        @(negedge wb_clk);
        step();
        check("rst_grant", 128'(grant), 128'(3));
        wb_rst_n = 1'b1;
        step();

        // Single read by m1
        req(1, 24'h000100, 1'b0, 3'b000);
        step();
        check("sr_grant", 128'(grant), 128'(1));
        check("sr_adr", 128'(s_adr), 128'(24'h000100));
        s_ack = 1'b1; s_dat_i = 32'hcafe_0100;
        #1 check("sr_acks", 128'({m2_ack, m1_ack, m0_ack}), 128'(3'b010));
        step();
        s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        step();
        check("sr_release", 128'(grant), 128'(3));
        idle_all();

        // Collision m0 vs m2
        req(0, 24'h000200, 1'b1, 3'b000);
        req(2, 24'h000300, 1'b0, 3'b000);
        step();
        check("col_first", 128'(grant), 128'(0));
        step();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        step();
        check("col_dead1", 128'(grant), 128'(3));
        step();
        check("col_dead2", 128'(grant), 128'(3));
        step();
        check("col_second", 128'(grant), 128'(2));
        idle_all();

        // Burst hold with m0 arriving mid-burst
        req(1, 24'h000000, 1'b0, 3'b010);
        step();
        req(0, 24'h000400, 1'b0, 3'b000);
        for (int b = 0; b < 2; b++) begin
            s_ack = 1'b1; s_dat_i = $urandom;
            step();
            check("burst_hold", 128'(grant), 128'(1));
            s_ack = 1'b0;
            step();
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (3) step();
        check("burst_next", 128'(grant), 128'(0));
        idle_all();

        // Starvation: m0 keeps re-requesting while m2 waits
        saw_m2 = 1'b0;
        req(2, 24'h000500, 1'b0, 3'b000);
        req(0, 24'h000600, 1'b0, 3'b000);
        for (int i = 0; i < 10; i++) begin
            cyc[0] = 1'b1; stb[0] = 1'b1;
            step(); if (grant == 2'd2) saw_m2 = 1'b1;
            step(); if (grant == 2'd2) saw_m2 = 1'b1;
            cyc[0] = 1'b0;
            step(); if (grant == 2'd2) saw_m2 = 1'b1;
            cyc[0] = 1'b1;
            step(); if (grant == 2'd2) saw_m2 = 1'b1;
        end
`ifdef SDRAM_ARB_STARVE_EN
        check("starve_m2", 128'(saw_m2), 128'(1));
`else
        check("starve_m2", 128'(saw_m2), 128'(0));
`endif
        idle_all();

        // Reset asserted mid-burst
        req(1, 24'h000700, 1'b0, 3'b010);
        step();
        s_ack = 1'b1;
        #2 wb_rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_grant_now", 128'(grant), 128'(3));
        check("rst_bus_now", 128'({s_cyc, s_stb}), 128'(0));
        check("rst_acks_now", 128'({m2_ack, m1_ack, m0_ack}), 128'(0));
        @(negedge wb_clk);
        s_ack = 1'b0;
        step();
        wb_rst_n = 1'b1;
        step();
        check("rst_rearb", 128'(grant), 128'(1));
        idle_all();

        // Abort: m2 drops cyc, late ack must reach nobody
        req(2, 24'h000800, 1'b0, 3'b000);
        step();
        cyc[2] = 1'b0; stb[2] = 1'b0;
        step();
        s_ack = 1'b1;
        #1 check("abort_acks", 128'({m2_ack, m1_ack, m0_ack}), 128'(0));
        step();
        idle_all();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 3; n++) begin
                if (cyc[n]) cyc[n] = ($urandom_range(7) != 0);
                else        cyc[n] = ($urandom_range(3) == 0);
                stb[n] = cyc[n] && ($urandom_range(3) != 0);
                adr[n] = 24'($urandom);
                dat[n] = $urandom;
                sel[n] = 4'($urandom);
                cti[n] = 3'($urandom);
                we[n]  = 1'($urandom);
            end
            s_ack   = ($urandom_range(2) == 0);
            s_dat_i = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
